// File: rtl/spio_serial_gen2.sv
// spio_serial_gen2: CPU-writable GPIO/LED/counter-select register set plus a
// serial streamer that pushes the LED pattern into an external shift-register
// chain with a clear / shift / latch sequence.
module spio_serial_gen2 #(
    parameter int                  LED_BITS   = 16,
    parameter int                  GPIO_BITS  = 14,
    parameter int                  DIV        = 2,
    parameter bit                  ACTIVE_LOW = 1'b1,
    parameter logic [LED_BITS-1:0] RST_LED    = 'h002A
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN,
    input  logic [31:0]          P_Data,
    input  logic                 start,
    input  logic                 auto_refresh,
    input  logic                 lsb_first,
    output logic [1:0]           counter_set,
    output logic [GPIO_BITS-1:0] GPIOf0,
    output logic [LED_BITS-1:0]  LED_out,
    output logic                 led_clk,
    output logic                 led_sout,
    output logic                 led_clrn,
    output logic                 LED_PEN,
    output logic                 busy,
    output logic                 done
);

    localparam int USED_BITS = 2 + LED_BITS + GPIO_BITS;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W     = $clog2(LED_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LED_BITS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, LATCH} state_t;

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [LED_BITS-1:0]  frame_reg, frame_next;
    logic                 led_clk_reg, led_clk_next;
    logic                 sout_reg, sout_next;
    logic                 clrn_reg, clrn_next;
    logic                 pen_reg, pen_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 dirty_reg, dirty_next;

    logic [1:0]           cs_reg;
    logic [GPIO_BITS-1:0] gpio_reg;
    logic [LED_BITS-1:0]  led_reg;

    logic [1:0]           wr_cs;
    logic [LED_BITS-1:0]  wr_led;
    logic [GPIO_BITS-1:0] wr_gpio;
    logic [LED_BITS-1:0]  led_src;
    logic [LED_BITS-1:0]  led_pol;
    logic [LED_BITS-1:0]  led_rev;
    logic [LED_BITS-1:0]  cap_frame;

    assign wr_cs   = P_Data[1:0];
    assign wr_led  = P_Data[LED_BITS+1:2];
    assign wr_gpio = P_Data[USED_BITS-1:LED_BITS+2];

    // Upper write-data bits beyond the three fields carry no meaning.
    generate
        if (USED_BITS < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^P_Data[31:USED_BITS];
        end
    endgenerate

    // A write landing on the capture edge is shifted out immediately.
    assign led_src   = EN ? wr_led : led_reg;
    assign led_pol   = ACTIVE_LOW ? ~led_src : led_src;

    // Frame is always shifted from bit 0, so MSB-first means a reversed copy.
    generate
        for (genvar gi = 0; gi < LED_BITS; gi++) begin : g_rev
            assign led_rev[gi] = led_pol[LED_BITS-1-gi];
        end
    endgenerate

    assign cap_frame = lsb_first ? led_pol : led_rev;

    // CPU register set: all three fields load together on a write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_reg   <= '0;
            gpio_reg <= '0;
            led_reg  <= RST_LED;
        end else if (EN) begin
            cs_reg   <= wr_cs;
            gpio_reg <= wr_gpio;
            led_reg  <= wr_led;
        end
    end

    // Streamer state and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_reg     <= '0;
            frame_reg   <= '0;
            led_clk_reg <= 1'b0;
            sout_reg    <= 1'b0;
            clrn_reg    <= 1'b1;
            pen_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dirty_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_reg     <= bit_next;
            frame_reg   <= frame_next;
            led_clk_reg <= led_clk_next;
            sout_reg    <= sout_next;
            clrn_reg    <= clrn_next;
            pen_reg     <= pen_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            dirty_reg   <= dirty_next;
        end
    end

    // Next-state logic: each phase lasts DIV cycles, counted by div_reg.
    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        bit_next     = bit_reg;
        frame_next   = frame_reg;
        led_clk_next = led_clk_reg;
        sout_next    = sout_reg;
        clrn_next    = clrn_reg;
        pen_next     = pen_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        dirty_next   = dirty_reg;

        // A rewrite during a frame guarantees exactly one follow-up frame.
        if (EN && busy_reg) begin
            dirty_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start || auto_refresh || dirty_reg) begin
                    state_next = CLEAR;
                    busy_next  = 1'b1;
                    clrn_next  = 1'b0;
                    div_next   = '0;
                    frame_next = cap_frame;
                    dirty_next = 1'b0;
                end
            end
            CLEAR: begin
                if (div_reg == DIV_LAST) begin
                    state_next   = SHIFT;
                    clrn_next    = 1'b1;
                    div_next     = '0;
                    bit_next     = '0;
                    led_clk_next = 1'b0;
                    sout_next    = frame_reg[0];
                    frame_next   = frame_reg >> 1;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (!led_clk_reg) begin
                        led_clk_next = 1'b1;
                    end else begin
                        led_clk_next = 1'b0;
                        if (bit_reg == BIT_LAST) begin
                            state_next = LATCH;
                            pen_next   = 1'b1;
                        end else begin
                            bit_next   = bit_reg + 1'b1;
                            sout_next  = frame_reg[0];
                            frame_next = frame_reg >> 1;
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            LATCH: begin
                if (div_reg == DIV_LAST) begin
                    state_next = IDLE;
                    pen_next   = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    div_next   = '0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign counter_set = cs_reg;
    assign GPIOf0      = gpio_reg;
    assign LED_out     = led_reg;
    assign led_clk     = led_clk_reg;
    assign led_sout    = sout_reg;
    assign led_clrn    = clrn_reg;
    assign LED_PEN     = pen_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_spio_serial_gen2.sv
// Testbench for spio_serial_gen2: two instances (DIV=1 active-low, DIV=3
// active-high) share stimulus; a frame-level monitor checks every frame.
module tb_spio_serial_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        EN = 1'b0;
    logic        start = 1'b0;
    logic        auto_refresh = 1'b0;
    logic        lsb_first = 1'b0;
    logic [31:0] P_Data = '0;

    wire [1:0]  busy_v, done_v, lclk_v, sout_v, clrn_v, pen_v;
    wire [1:0]  cs_v   [2];
    wire [13:0] gpio_v [2];
    wire [15:0] led_v  [2];

    spio_serial_gen2 #(.LED_BITS(16), .GPIO_BITS(14), .DIV(1), .ACTIVE_LOW(1'b1), .RST_LED(16'h002A)) dut_a (
        .clk(clk), .rst(rst), .EN(EN), .P_Data(P_Data), .start(start),
        .auto_refresh(auto_refresh), .lsb_first(lsb_first),
        .counter_set(cs_v[0]), .GPIOf0(gpio_v[0]), .LED_out(led_v[0]),
        .led_clk(lclk_v[0]), .led_sout(sout_v[0]), .led_clrn(clrn_v[0]),
        .LED_PEN(pen_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    spio_serial_gen2 #(.LED_BITS(16), .GPIO_BITS(14), .DIV(3), .ACTIVE_LOW(1'b0), .RST_LED(16'h002A)) dut_b (
        .clk(clk), .rst(rst), .EN(EN), .P_Data(P_Data), .start(start),
        .auto_refresh(auto_refresh), .lsb_first(lsb_first),
        .counter_set(cs_v[1]), .GPIOf0(gpio_v[1]), .LED_out(led_v[1]),
        .led_clk(lclk_v[1]), .led_sout(sout_v[1]), .led_clrn(clrn_v[1]),
        .LED_PEN(pen_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit al_of(input int i);
        return (i == 0) ? 1'b1 : 1'b0;
    endfunction

    // Bit k of the result is the k-th bit the chain should receive.
    function automatic logic [15:0] frame_of(input logic [15:0] v, input logic lsb, input bit al);
        logic [15:0] d;
        logic [15:0] f;
        d = al ? ~v : v;
        for (int k = 0; k < 16; k++) f[k] = lsb ? d[k] : d[15-k];
        return f;
    endfunction

    // Reference register model and inputs as seen at each rising edge.
    logic        rst_e, start_e, auto_e, en_e, lsb_e;
    logic [15:0] led_m;
    logic [13:0] gpio_m;
    logic [1:0]  cs_m;

    always @(posedge clk) begin
        rst_e   <= rst;
        start_e <= start;
        auto_e  <= auto_refresh;
        en_e    <= EN;
        lsb_e   <= lsb_first;
        if (rst) begin
            led_m  <= 16'h002A;
            gpio_m <= '0;
            cs_m   <= '0;
        end else if (EN) begin
            led_m  <= P_Data[17:2];
            gpio_m <= P_Data[31:18];
            cs_m   <= P_Data[1:0];
        end
    end

    // Frame-level monitor state per instance.
    int          busy_cnt [2], clrn_cnt [2], pen_cnt [2], nbits [2], idle_cnt [2];
    int          frames_done [2] = '{0, 0};
    int          last_gap [2] = '{0, 0};
    int          last_busy [2] = '{0, 0};
    logic [15:0] bits_got [2], exp_vec [2], last_bits [2], prev_bits [2];
    logic        busy_prev [2], lclk_prev [2], dirty_m [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("regs", {cs_v[i], gpio_v[i], led_v[i]}, {cs_m, gpio_m, led_m});
            if (rst_e) begin
                check("rst_outs", {busy_v[i], done_v[i], lclk_v[i], sout_v[i], clrn_v[i], pen_v[i]}, 32'b000010);
                busy_prev[i] <= 1'b0;
                lclk_prev[i] <= 1'b0;
                dirty_m[i]   <= 1'b0;
                idle_cnt[i]  <= 0;
            end else begin
                if (!busy_prev[i]) begin
                    check("frame_start", busy_v[i], start_e | auto_e | dirty_m[i]);
                    check("done_idle", done_v[i], 1'b0);
                    if (busy_v[i]) begin
                        exp_vec[i]  <= frame_of(led_m, lsb_e, al_of(i));
                        busy_cnt[i] <= 1;
                        clrn_cnt[i] <= clrn_v[i] ? 0 : 1;
                        pen_cnt[i]  <= 0;
                        nbits[i]    <= 0;
                        bits_got[i] <= '0;
                        last_gap[i] <= idle_cnt[i];
                        dirty_m[i]  <= 1'b0;
                    end else begin
                        idle_cnt[i] <= idle_cnt[i] + 1;
                    end
                end else if (busy_v[i]) begin
                    check("done_busy", done_v[i], 1'b0);
                    busy_cnt[i] <= busy_cnt[i] + 1;
                    if (!clrn_v[i]) clrn_cnt[i] <= clrn_cnt[i] + 1;
                    if (pen_v[i]) pen_cnt[i] <= pen_cnt[i] + 1;
                    if (lclk_v[i] && !lclk_prev[i]) begin
                        if (nbits[i] < 16) bits_got[i][nbits[i][3:0]] <= sout_v[i];
                        nbits[i] <= nbits[i] + 1;
                    end
                    if (en_e) dirty_m[i] <= 1'b1;
                end else begin
                    check("done_pulse", done_v[i], 1'b1);
                    check("busy_len", busy_cnt[i], div_of(i) * 34);
                    check("clrn_len", clrn_cnt[i], div_of(i));
                    check("pen_len", pen_cnt[i], div_of(i));
                    check("nbits", nbits[i], 16);
                    check("frame_bits", bits_got[i], exp_vec[i]);
                    check("end_pins", {lclk_v[i], clrn_v[i], pen_v[i]}, 3'b010);
                    if (en_e) dirty_m[i] <= 1'b1;
                    idle_cnt[i]    <= 1;
                    frames_done[i] <= frames_done[i] + 1;
                    last_busy[i]   <= busy_cnt[i];
                    prev_bits[i]   <= last_bits[i];
                    last_bits[i]   <= bits_got[i];
                end
                busy_prev[i] <= busy_v[i];
                lclk_prev[i] <= lclk_v[i];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int i, input int target, input int budget);
        int n = 0;
        while (frames_done[i] < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_timeout", 32'(frames_done[i] >= target), 1);
    endtask

    int fa, fb;

    initial begin
        // 1: reset values
        step(2);
        check("t1_led", led_v[0], 16'h002A);
        check("t1_gpio_cs", {gpio_v[0], cs_v[0]}, 0);
        check("t1_pins", {busy_v[0], lclk_v[0], clrn_v[0], pen_v[0]}, 4'b0010);
        rst = 1'b0;
        step(2);

        // 2: register write, then LSB-first frame
        EN = 1'b1;
        P_Data = {14'h1234, 16'h00A5, 2'b10};
        step(1);
        EN = 1'b0;
        check("t2_gpio", gpio_v[0], 14'h1234);
        check("t2_led", led_v[0], 16'h00A5);
        check("t2_cs", cs_v[0], 2'b10);
        fa = frames_done[0];
        fb = frames_done[1];
        lsb_first = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t2_busy_rise", busy_v[0], 1'b1);
        wait_frames(0, fa + 1, 100);
        wait_frames(1, fb + 1, 200);
        check("t2_bits_a", last_bits[0], 16'hFF5A);
        check("t2_bits_b", last_bits[1], 16'h00A5);
        check("t2_busy_a", last_busy[0], 34);
        check("t2_busy_b", last_busy[1], 102);

        // 3: MSB-first frame
        lsb_first = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_frames(0, fa + 2, 100);
        wait_frames(1, fb + 2, 200);
        check("t3_bits_a", last_bits[0], 16'h5AFF);
        check("t3_bits_b", last_bits[1], 16'hA500);

        // 4: rewrite at cycle 10 of a frame forces one re-send
        fa = frames_done[0];
        fb = frames_done[1];
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        EN = 1'b1;
        P_Data = {14'h1234, 16'hFFFF, 2'b10};
        step(1);
        EN = 1'b0;
        check("t4_led", led_v[0], 16'hFFFF);
        wait_frames(0, fa + 2, 120);
        wait_frames(1, fb + 2, 300);
        check("t4_first_a", prev_bits[0], 16'h5AFF);
        check("t4_second_a", last_bits[0], 16'h0000);
        check("t4_gap_a", last_gap[0], 1);
        check("t4_second_b", last_bits[1], 16'hFFFF);
        step(40);
        check("t4_no_third_a", frames_done[0], fa + 2);
        check("t4_no_third_b", frames_done[1], fb + 2);

        // 5: write and start together from IDLE
        fa = frames_done[0];
        fb = frames_done[1];
        EN = 1'b1;
        start = 1'b1;
        lsb_first = 1'b1;
        P_Data = {14'h1234, 16'h0001, 2'b10};
        step(1);
        EN = 1'b0;
        start = 1'b0;
        wait_frames(0, fa + 1, 100);
        wait_frames(1, fb + 1, 200);
        check("t5_first_bit", last_bits[0][0], 1'b0);
        check("t5_bits_a", last_bits[0], 16'hFFFE);
        check("t5_bits_b", last_bits[1], 16'h0001);
        step(40);
        check("t5_single", frames_done[0], fa + 1);

        // 6: reset in SHIFT bit 7, then auto-refresh
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(15);
        fa = frames_done[0];
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_pins", {busy_v[0], done_v[0], lclk_v[0], sout_v[0], clrn_v[0], pen_v[0]}, 32'b000010);
        check("t6_rst_led", led_v[0], 16'h002A);
        check("t6_rst_b", {busy_v[1], pen_v[1]}, 2'b00);
        step(5);
        check("t6_no_pen", {pen_v[0], busy_v[0]}, 2'b00);
        check("t6_no_frame", frames_done[0], fa);
        auto_refresh = 1'b1;
        step(300);
        auto_refresh = 1'b0;
        check("t6_auto_count", 32'(frames_done[0] - fa >= 8), 1);
        check("t6_gap_a", last_gap[0], 1);
        check("t6_gap_b", last_gap[1], 1);
        check("t6_busy_a", last_busy[0], 34);
        step(250);

        // Random traffic checked by the frame monitor.
        for (int c = 0; c < 2000; c++) begin
            EN = ($urandom_range(0, 15) == 0);
            P_Data = $urandom;
            start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) auto_refresh = ~auto_refresh;
            lsb_first = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 799) == 0);
            step(1);
        end
        EN = 1'b0;
        start = 1'b0;
        auto_refresh = 1'b0;
        rst = 1'b0;
        step(300);
        check("final_idle", {busy_v[0], busy_v[1]}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spio_serial_gen2.md
Name: spio_serial_gen2

Overview:
Parametrised successor to the board's serial peripheral I/O block. It holds a CPU-writable register set with three fields: GPIO output bits, an LED pattern and counter-select bits. It streams the LED pattern to an external shift-register chain using a clear / shift / latch protocol. Compared with the previous generation it adds:
- generic widths
- a programmable serial clock divider
- selectable bit order and polarity
- auto-refresh
- automatic re-send when the pattern is rewritten mid-frame
- busy/done status
It sits on the CPU peripheral bus next to the counter and 7-segment blocks.

Parameters:
LED_BITS, 16, width of the LED register and of the serial frame (4..29)
GPIO_BITS, 14, width of the GPIO field; constraint 2+LED_BITS+GPIO_BITS <= 32
DIV, 2, clk cycles per serial half-period (>=1)
ACTIVE_LOW, 1, 1 = invert LED data before shifting (LEDs sink current)
RST_LED, 16'h002A, LED register reset value (low LED_BITS bits used)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
EN  in  1  write strobe for P_Data
P_Data  in  32  write data = {unused, GPIO[GPIO_BITS-1:0], LED[LED_BITS-1:0], counter_set[1:0]}
start  in  1  request one frame transmission
auto_refresh  in  1  1 = transmit continuously while high
lsb_first  in  1  1 = LED[0] shifted out first, 0 = LED[LED_BITS-1] first
counter_set  out  2  registered counter-select field
GPIOf0  out  GPIO_BITS  registered GPIO field
LED_out  out  LED_BITS  registered LED field
led_clk  out  1  serial shift clock
led_sout  out  1  serial data
led_clrn  out  1  chain clear, active-low
LED_PEN  out  1  output-latch enable pulse
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse after a frame completes

Behaviour:
- Reset (clk edge with rst=1): every state element returns to its reset value, including mid-frame, and the frame is aborted.
  - counter_set=0, GPIOf0=0, LED_out=RST_LED
  - led_clk=0, led_sout=0, led_clrn=1, LED_PEN=0
  - busy=0, done=0, dirty=0, FSM=IDLE
- Register write: EN=1 loads all three fields from their P_Data slices on that edge, in any FSM state. Unused upper P_Data bits are ignored.
- Frame capture, on leaving IDLE:
  - frame = ACTIVE_LOW ? ~LED : LED, ordered per lsb_first; lsb_first is sampled at that point.
  - If EN and start fall in the same cycle, the frame uses the new P_Data LED slice (write-first bypass).
- FSM states and transitions:
  - IDLE: go to CLEAR when start=1, auto_refresh=1 or dirty=1; busy rises on the same edge.
  - CLEAR: led_clrn=0 for DIV cycles, then SHIFT.
  - SHIFT: LED_BITS bits. Per bit: led_sout is updated while led_clk=0 and held for DIV cycles, then led_clk=1 for DIV cycles. The external chain samples on the led_clk rising edge. After the last bit led_clk returns to 0 and the FSM goes to LATCH.
  - LATCH: LED_PEN=1 for DIV cycles. On exit: busy=0, done=1 for one cycle, FSM returns to IDLE.
- Timing: busy is high for exactly DIV*(2*LED_BITS+2) cycles. The earliest next frame starts on the cycle after done, so consecutive frames have a 1-cycle IDLE gap.
- dirty flag: an EN write while busy=1 sets dirty. dirty clears when the next frame is captured, so a mid-frame rewrite is always followed by exactly one more frame. EN while idle does not set dirty.
- start while busy is ignored and is not queued.
- Counters: the divider and bit counter are sized by clog2. The bit counter wraps only via the FSM transition, never modulo.

Test Plan:
1. Reset -> LED_out=16'h002A, GPIOf0=0, counter_set=0, led_clrn=1, LED_PEN=0, busy=0, led_clk=0.
2. Setup: defaults with DIV=1, write P_Data={14'h1234,16'h00A5,2'b10}, then start with lsb_first=1.
   - Registers: GPIOf0=14'h1234, LED_out=16'h00A5, counter_set=2'b10.
   - Bits at the 16 led_clk rising edges: 0,1,0,1,1,0,1,0 then eight 1s.
   - Strobes: led_clrn low 1 cycle, LED_PEN high 1 cycle.
   - busy high 34 cycles, then done pulse.
3. Same data with lsb_first=0, ACTIVE_LOW=0 -> sout bits are eight 0s, then 1,0,1,0,0,1,0,1.
4. EN write LED=16'hFFFF at cycle 10 of a frame -> current frame still shifts the old pattern; a second frame follows automatically, 1 cycle after done, shifting all 0s (ACTIVE_LOW=1); no third frame.
5. EN and start in the same cycle from IDLE with LED=16'h0001 -> the first shifted bit reflects the new value (0 with lsb_first=1, ACTIVE_LOW=1).
6. Assert rst during SHIFT bit 7 -> on the next edge all outputs take reset values with no LED_PEN pulse. Then hold auto_refresh=1 -> back-to-back frames, each 34 cycles busy with a 1-cycle gap.
